// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forward selects, multiply
// sequencer state encoding and the PC register address.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] PC_ADDR = 4'hF;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/hazard_ctrl_mul_seq.sv
// Multiply sequencer: holds the pipeline frozen while a multi-cycle multiply
// occupies Execute and pulses MulDoneE when its result is ready.
//
// state    | meaning
// MUL_IDLE | no multiply in flight; a MulStartE is accepted here
// MUL_BUSY | multiply in flight; cnt counts down the remaining frozen cycles
module mul_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MulStartE,
  output logic freeze,
  output logic MulBusy,
  output logic MulDoneE
);

  localparam int CW      = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int INIT_I  = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
  localparam logic [CW-1:0] CNT_INIT = INIT_I[CW-1:0];
  localparam bit MULTI   = (MUL_LATENCY > 1);

  mul_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (MulStartE && MULTI) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Outputs are gated by rst_n so an asserted reset releases the pipeline at once.
  always_comb begin
    freeze   = 1'b0;
    MulDoneE = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        freeze   = MulStartE && MULTI;
        MulDoneE = MulStartE && !MULTI;
      end
      MUL_BUSY: begin
        freeze   = (cnt_q != '0);
        MulDoneE = (cnt_q == '0);
      end
      default: ;
    endcase
    freeze   = freeze & rst_n;
    MulDoneE = MulDoneE & rst_n;
  end

  assign MulBusy = (state_q == MUL_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use / RAW stalls,
// branch flushes and multiply freeze. Forwarding is enabled by HAZARD_FWD_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulBusy,
  output logic       MulDoneE
);

  logic freeze;
  logic hz;

  mul_seq #(.MUL_LATENCY(MUL_LATENCY)) u_mul_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .MulStartE(MulStartE),
    .freeze   (freeze),
    .MulBusy  (MulBusy),
    .MulDoneE (MulDoneE)
  );

`ifdef HAZARD_FWD_EN
  // Memory stage is checked first so the youngest result wins.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RA1E != PC_ADDR) begin
      if (RegWriteM && (WA3M == RA1E))      ForwardAE = FWD_MEM;
      else if (RegWriteW && (WA3W == RA1E)) ForwardAE = FWD_WB;
    end
    if (RA2E != PC_ADDR) begin
      if (RegWriteM && (WA3M == RA2E))      ForwardBE = FWD_MEM;
      else if (RegWriteW && (WA3W == RA2E)) ForwardBE = FWD_WB;
    end
  end

  assign hz = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
`else
  function automatic logic dst_hit(input logic we, input logic [3:0] wa,
                                   input logic [3:0] ra1, input logic [3:0] ra2);
    return we && (wa != PC_ADDR) && ((wa == ra1) || (wa == ra2));
  endfunction

  // Without forwarding, any in-flight writer of a Decode source must drain first.
  assign ForwardAE = FWD_RF;
  assign ForwardBE = FWD_RF;
  assign hz = dst_hit(RegWriteE, WA3E, RA1D, RA2D)
            | dst_hit(RegWriteM, WA3M, RA1D, RA2D)
            | dst_hit(RegWriteW, WA3W, RA1D, RA2D);

  logic unused_ok;
  assign unused_ok = ^{MemtoRegE, RA1E, RA2E};
`endif

  assign StallF = freeze | (hz & ~BranchTakenE);
  assign StallD = freeze | (hz & ~BranchTakenE);
  assign StallE = freeze;
  assign StallM = freeze;
  assign StallW = freeze;
  assign FlushD = ~freeze & BranchTakenE;
  assign FlushE = ~freeze & (BranchTakenE | hz);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulStartE;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MulBusy, MulDoneE;

  int total = 0;
  int bad   = 0;
  int m_age = -1;
  int m_cur = -1;
  logic [12:0] obs, exp_v;

  hazard_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulBusy(MulBusy), .MulDoneE(MulDoneE)
  );

  always #5 clk = ~clk;

  assign obs = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
                ForwardAE, ForwardBE, MulBusy, MulDoneE};

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    logic [1:0] r = 2'b00;
`ifdef HAZARD_FWD_EN
    if (ra == 4'hF) r = 2'b00;
    else if (RegWriteM && WA3M == ra) r = 2'b10;
    else if (RegWriteW && WA3W == ra) r = 2'b01;
`else
    r = ra & 4'h0;
`endif
    return r;
  endfunction

  function automatic logic ref_hazard();
`ifdef HAZARD_FWD_EN
    return MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
`else
    logic [3:0] dst [3];
    logic       we  [3];
    dst = '{WA3E, WA3M, WA3W};
    we  = '{RegWriteE, RegWriteM, RegWriteW};
    for (int k = 0; k < 3; k++)
      if (we[k] && dst[k] != 4'hF && (dst[k] == RA1D || dst[k] == RA2D)) return 1'b1;
    return 1'b0;
`endif
  endfunction

  // m_age is the age of the multiply in Execute (cycles since acceptance), -1 when none.
  task automatic model_eval();
    logic frz, dn, busy, sf, sd, fd, fe;
    if (!rst_n)          m_cur = -1;
    else if (m_age >= 1) m_cur = m_age;
    else                 m_cur = MulStartE ? 0 : -1;
    busy = rst_n && (m_age >= 1);
    frz  = (m_cur >= 0) && (m_cur < LAT - 1);
    dn   = (m_cur >= 0) && (m_cur == LAT - 1);
    sf = frz; sd = frz; fd = 1'b0; fe = 1'b0;
    if (!frz) begin
      if (BranchTakenE) begin
        fd = 1'b1; fe = 1'b1;
      end else if (ref_hazard()) begin
        sf = 1'b1; sd = 1'b1; fe = 1'b1;
      end
    end
    exp_v = {sf, sd, frz, frz, frz, fd, fe, ref_fwd(RA1E), ref_fwd(RA2E), busy, dn};
  endtask

  task automatic model_advance();
    if (!rst_n) m_age = -1;
    else        m_age = (m_cur >= 0 && m_cur < LAT - 1) ? m_cur + 1 : -1;
  endtask

  task automatic clear_inputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; BranchTakenE = 0; MulStartE = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_hold obs=%b exp=%b", obs, 13'd0);
    end
    @(posedge clk); m_age = -1; #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      model_eval();
      total++;
      if (obs !== 13'd0 || exp_v !== 13'd0) begin
        bad++; $display("FAIL reset_release obs=%b exp=%b", obs, 13'd0);
      end
      @(posedge clk); model_advance(); #1;
    end
  endtask

`ifdef HAZARD_FWD_EN
  task automatic test_forward();
    clear_inputs();
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
    #1; total++;
    if (ForwardAE !== 2'b10) begin
      bad++; $display("FAIL fwd_mem_wins obs=%b exp=10", ForwardAE);
    end
    RA1E = 15; WA3M = 15; WA3W = 15;
    #1; total++;
    if (ForwardAE !== 2'b00) begin
      bad++; $display("FAIL fwd_pc obs=%b exp=00", ForwardAE);
    end
    RegWriteM = 0; WA3W = 7; RA2E = 7;
    #1; total++;
    if (ForwardBE !== 2'b01) begin
      bad++; $display("FAIL fwd_wb obs=%b exp=01", ForwardBE);
    end
    clear_inputs();
  endtask
`else
  task automatic test_raw();
    clear_inputs();
    RegWriteM = 1; WA3M = 2; RA1D = 2;
    #1; total++;
    if ({StallF, StallD, FlushE, ForwardAE} !== 5'b11100) begin
      bad++; $display("FAIL raw_mem obs=%b exp=11100", {StallF, StallD, FlushE, ForwardAE});
    end
    RegWriteM = 0; RegWriteW = 1; WA3W = 15; RA1D = 15;
    #1; total++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      bad++; $display("FAIL raw_pc obs=%b exp=000", {StallF, StallD, FlushE});
    end
    clear_inputs();
  endtask
`endif

  task automatic test_loaduse();
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    #1; total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      bad++; $display("FAIL loaduse obs=%b exp=1101", {StallF, StallD, FlushD, FlushE});
    end
    BranchTakenE = 1;
    #1; total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      bad++; $display("FAIL branch_over_load obs=%b exp=0011", {StallF, StallD, FlushD, FlushE});
    end
    clear_inputs();
  endtask

  task automatic test_mul_back_to_back();
    logic [6:0] want;
    clear_inputs();
    @(posedge clk); model_advance(); #1;
    MulStartE = 1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      model_eval();
      want = {{5{(i % LAT) < LAT - 1}}, (i % LAT) != 0, (i % LAT) == LAT - 1};
      total++;
      if ({StallF, StallD, StallE, StallM, StallW, MulBusy, MulDoneE} !== want) begin
        bad++; $display("FAIL mul_cycle%0d obs=%b exp=%b", i,
                        {StallF, StallD, StallE, StallM, StallW, MulBusy, MulDoneE}, want);
      end
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL mul_model%0d obs=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); model_advance(); #1;
    end
    MulStartE = 0;
  endtask

  task automatic test_reset_mid_mul();
    clear_inputs();
    MulStartE = 1;
    @(negedge clk); model_eval();
    @(posedge clk); model_advance(); #1;
    rst_n = 0; MulStartE = 0;
    #1; total++;
    if ({StallF, StallD, StallE, StallM, StallW, MulBusy, MulDoneE} !== 7'd0) begin
      bad++; $display("FAIL reset_mid_mul obs=%b exp=0000000",
                      {StallF, StallD, StallE, StallM, StallW, MulBusy, MulDoneE});
    end
    m_age = -1;
    #1 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      model_eval();
      total++;
      if (MulDoneE !== 1'b0 || obs !== exp_v) begin
        bad++; $display("FAIL after_reset%0d obs=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); model_advance(); #1;
    end
  endtask

  function automatic logic [3:0] rnd_addr();
    return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RA1D = rnd_addr(); RA2D = rnd_addr(); RA1E = rnd_addr(); RA2E = rnd_addr();
      WA3E = rnd_addr(); WA3M = rnd_addr(); WA3W = rnd_addr();
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      BranchTakenE = ($urandom_range(0, 3) == 0);
      MulStartE    = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      model_eval();
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL random%0d obs=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); model_advance(); #1;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
`ifdef HAZARD_FWD_EN
    test_forward();
`else
    test_raw();
`endif
    test_loaduse();
    test_mul_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It generates every stall and flush for the F/D, D/E, E/M and M/W pipeline registers, and the operand-forwarding selects for the Execute stage. It also sequences the multi-cycle multiplier by freezing the pipeline while a multiply occupies Execute. It is the only source of `Stall*`/`Flush*` in the core; every pipeline register consumes its outputs.

## Interface
Parameters:
- `MUL_LATENCY`, default 4: Execute cycles a multiply occupies; legal range 1..16.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RA1D`, `RA2D`  in  4 each  source register addresses in Decode.
- `RA1E`, `RA2E`  in  4 each  source register addresses in Execute.
- `WA3E`, `WA3M`, `WA3W`  in  4 each  destination addresses in E, M and W.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each  register-write enables per stage.
- `MemtoRegE`  in  1  the instruction in Execute is a load.
- `BranchTakenE`  in  1  taken branch or PC write resolved in Execute.
- `MulStartE`  in  1  the instruction in Execute is a multiply.
- `StallF`, `StallD`, `StallE`, `StallM`, `StallW`  out  1 each  hold the corresponding pipeline register.
- `FlushD`, `FlushE`  out  1 each  load a bubble into the D or E register.
- `ForwardAE`, `ForwardBE`  out  2 each  operand source select: 00 register file, 01 Writeback result, 10 Memory-stage ALU result.
- `MulBusy`  out  1  multiply sequencer is not IDLE.
- `MulDoneE`  out  1  one-cycle pulse; the multiplier result is valid in Execute this cycle.

## Operation
- **Forwarding (combinational):** `ForwardAE` = 10 if `RegWriteM` and `WA3M==RA1E`; otherwise 01 if `RegWriteW` and `WA3W==RA1E`; otherwise 00. `ForwardBE` is the same with `RA2E`. The M stage wins when M and W both match. Address 4'hF (PC) is never forwarded.
- **Load-use stall:** `ldstall` = `MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D)`. It asserts `StallF`, `StallD` and `FlushE`.
- **Branch:** `BranchTakenE` asserts `FlushD` and `FlushE`.
- **Multiply sequencer:** two states, IDLE and BUSY, plus a down-counter `cnt` of width `$clog2(MUL_LATENCY)` (minimum 1 bit).
  - In IDLE with `MulStartE` and `MUL_LATENCY>1`: `freeze`=1; next state BUSY; `cnt` ← `MUL_LATENCY-2`.
  - In BUSY with `cnt!=0`: `freeze`=1; `cnt` decrements.
  - In BUSY with `cnt==0`: `MulDoneE`=1; `freeze`=0; next state IDLE.
  - `MulStartE` is ignored while in BUSY.
  - With `MUL_LATENCY==1`, `MulDoneE` = `MulStartE` in IDLE; there is no freeze and the state stays IDLE.
- **Freeze:** asserts all five `Stall*` outputs. Repeated writes of an identical register-file or memory write while frozen are idempotent, so they are permitted.
- **Priority:** reset > `freeze` > branch > `ldstall`.
  - While `freeze` is asserted, both flushes and `ldstall` are suppressed.
  - When a branch and `ldstall` occur together, the branch wins: `FlushD`=1, `FlushE`=1, `StallF`=0, `StallD`=0.

## Timing
- Reset (asynchronous, immediate): state IDLE, `cnt`=0, `MulBusy`=0, `MulDoneE`=0. With all inputs at 0, every output is 0.
- Reset asserted mid-BUSY drops `freeze` in the same cycle. No partial multiply survives.
- Forwarding, `ldstall` and branch outputs are combinational, with zero latency from the inputs.
- A multiply accepted in cycle 0 freezes the pipeline for cycles 0..`MUL_LATENCY-2`. `MulDoneE` pulses in cycle `MUL_LATENCY-1`, with no stalls that cycle.
- `MulBusy` is registered; it is high from cycle 1 through cycle `MUL_LATENCY-1`.
- Back-to-back multiplies: the second enters Execute the cycle after `MulDoneE` and starts a new sequence with no idle gap.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Forwarding operates as specified above.
- `HAZARD_FWD_EN` undefined:
  - `ForwardAE` and `ForwardBE` are tied to 00.
  - `ldstall` is replaced by `rawstall`, which is true when any of `RegWriteE`, `RegWriteM` or `RegWriteW` is set and that stage's destination matches `RA1D` or `RA2D` (4'hF excluded).
  - `rawstall` asserts `StallF`, `StallD` and `FlushE`, with the same priority slot as `ldstall`.

## Structure
- Shared package `hazard_pkg` holds:
  - forward-select constants `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - multiply-sequencer state encoding `MUL_IDLE`=0, `MUL_BUSY`=1.
- Sub-module `mul_seq` contains the multiply FSM and counter and outputs `freeze`, `MulBusy` and `MulDoneE`. The top level contains the forwarding logic, the hazard detection and the priority merge.

## Test plan
- Reset with all inputs 0 → all outputs 0. Release reset → outputs remain 0.
- `RegWriteM`=1, `WA3M`=3, `RegWriteW`=1, `WA3W`=3, `RA1E`=3 → `ForwardAE`=10. Same with `RA1E`=15 → `ForwardAE`=00.
- `MemtoRegE`=1, `RegWriteE`=1, `WA3E`=5, `RA2D`=5 → `StallF`=1, `StallD`=1, `FlushE`=1. Add `BranchTakenE`=1 → `FlushD`=1, `FlushE`=1, `StallF`=0.
- `MUL_LATENCY`=4, `MulStartE` held high → all `Stall*` high in cycles 0–2, `MulDoneE`=1 in cycle 3, `MulBusy` high in cycles 1–3.
- `rst_n` pulsed low in cycle 1 of a multiply → `Stall*`=0 immediately, state IDLE, `MulDoneE` never pulses.
- `HAZARD_FWD_EN` undefined, `RegWriteM`=1, `WA3M`=2, `RA1D`=2 → `StallF`=1, `StallD`=1, `FlushE`=1, `ForwardAE`=00.
